// File: rtl/cpu_ifu.sv
// cpu_ifu: instruction fetch unit feeding cpu_idu.
// Issues in-order word fetches, buffers returned words in a small prefetch
// FIFO and presents one instruction per cycle (NOP bubble when starved).
// Stalls on wait_exe and redirects on flush_flag together with cpu_idu.
module cpu_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_flag,
  input  logic [31:0] jmp_addr,
  input  logic        wait_exe,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);

  // Fetch side state
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      ret_pc_reg, ret_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] discard_reg, discard_next;

  // Prefetch FIFO
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [31:0]      addr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Output stage
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;

  logic [31:0]      jmp_aligned;
  logic [SUM_W-1:0] occupancy;
  logic             req_fire;
  logic             resp_ok;
  logic             resp_drop;
  logic             push;
  logic             pop;

  assign jmp_aligned = jmp_addr & 32'hFFFF_FFFC;

  // Buffered plus in-flight words never exceed the FIFO, so it cannot overflow.
  assign occupancy = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign imem_req  = rst_n && !flush_flag && (occupancy < DEPTH_S);
  assign imem_addr = fetch_pc_reg;
  assign req_fire  = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = imem_rvalid && (outstanding_reg != '0);
  assign resp_drop = resp_ok && (discard_reg != '0);
  // A word arriving in a flush cycle would be cleared anyway, so skip the push.
  assign push      = resp_ok && !resp_drop && !flush_flag;
  assign pop       = !flush_flag && !wait_exe && (count_reg != '0);

  assign instruction = instr_reg;
  assign pc_out      = pc_reg;

  // Next-state for fetch pointer, return-address counter and request bookkeeping.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    ret_pc_next      = ret_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (flush_flag) begin
      // Every request still in flight after this cycle's response is stale.
      outstanding_next = outstanding_reg - CNT_W'(resp_ok);
      discard_next     = outstanding_reg - CNT_W'(resp_ok);
      fetch_pc_next    = jmp_aligned;
      ret_pc_next      = jmp_aligned;
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (push) begin
        ret_pc_next = ret_pc_reg + 32'd4;
      end
      if (resp_drop) begin
        discard_next = discard_reg - CNT_W'(1);
      end
      outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(resp_ok);
    end
  end

  // Next-state for FIFO pointers and occupancy; a flush empties the buffer.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_flag) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      ret_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      ret_pc_reg      <= ret_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
    end
  end

  // FIFO storage: word and its fetch address written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_rdata;
      addr_mem[wr_ptr_reg] <= ret_pc_reg;
    end
  end

  // Output register: bubble on flush, hold on stall, else pop head or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= NOP_INST;
      pc_reg    <= RESET_PC;
    end else if (flush_flag) begin
      instr_reg <= NOP_INST;
    end else if (!wait_exe) begin
      if (pop) begin
        instr_reg <= data_mem[rd_ptr_reg];
        pc_reg    <= addr_mem[rd_ptr_reg];
      end else begin
        instr_reg <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ifu.sv
// tb_cpu_ifu: randomized bench for cpu_ifu with an in-order memory model and
// a queue-based reference model of the fetch stream, compared every cycle.
module tb_cpu_ifu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst_n;
  logic        flush_flag;
  logic [31:0] jmp_addr;
  logic        wait_exe;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  cpu_ifu #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INST  (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_flag (flush_flag),
    .jmp_addr   (jmp_addr),
    .wait_exe   (wait_exe),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: a word derived from its address, never equal to NOP.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
  } ent_t;

  // Reference model state (written only by the model process)
  ent_t        m_q[$];
  int          m_out   = 0;
  int          m_disc  = 0;
  logic [31:0] m_fetch = RESET_PC;
  logic [31:0] m_ret   = RESET_PC;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc    = RESET_PC;

  // Counters (written only by the compare process)
  int n_chk = 0;
  int n_err = 0;
  int lit_i = 0;

  // Written only by the compare process, read by the memory model
  bit          cap_hs   = 0;
  logic [31:0] cap_addr = '0;

  // Driver-owned stimulus knobs and literal delivery expectations
  logic [31:0] pend[$];
  int          gnt_pct   = 100;
  int          rv_pct    = 100;
  logic [31:0] lit_arr [64];
  int          lit_n     = 0;
  bit          final_chk = 0;
  bit          show_del  = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered words as a queue, in-flight and stale counts as integers.
  initial begin
    ent_t e;
    bit   resp;
    bit   req;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_out = 0; m_disc = 0;
        m_fetch = RESET_PC; m_ret = RESET_PC;
        m_instr = NOP; m_pc = RESET_PC;
      end else begin
        resp = imem_rvalid && (m_out > 0);
        req  = !flush_flag && ((m_q.size() + m_out) < DEPTH);
        if (flush_flag) begin
          m_out   = m_out - int'(resp);
          m_disc  = m_out;
          m_q.delete();
          m_fetch = jmp_addr & 32'hFFFF_FFFC;
          m_ret   = jmp_addr & 32'hFFFF_FFFC;
          m_instr = NOP;
        end else begin
          if (!wait_exe) begin
            if (m_q.size() > 0) begin
              e = m_q.pop_front();
              m_instr = e.data;
              m_pc    = e.addr;
            end else begin
              m_instr = NOP;
            end
          end
          if (resp) begin
            m_out = m_out - 1;
            if (m_disc > 0) begin
              m_disc = m_disc - 1;
            end else begin
              e.data = imem_rdata;
              e.addr = m_ret;
              m_q.push_back(e);
              m_ret = m_ret + 32'd4;
            end
          end
          if (req && imem_gnt) begin
            m_fetch = m_fetch + 32'd4;
            m_out   = m_out + 1;
          end
        end
      end
    end
  end

  // Compare process: checks DUT outputs against the model every falling edge.
  initial begin
    bit          prev_nop;
    logic [31:0] prev_pc;
    bit          exp_req;
    bit          fin_done;
    prev_nop = 1; prev_pc = RESET_PC; fin_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_instruction", instruction, NOP);
        check("rst_pc_out", pc_out, RESET_PC);
        prev_nop = 1;
        prev_pc  = RESET_PC;
      end else begin
        exp_req = !flush_flag && ((m_q.size() + m_out) < DEPTH);
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check("imem_addr", imem_addr, m_fetch);
        check("instruction", instruction, m_instr);
        check("pc_out", pc_out, m_pc);
        if (instruction != NOP) begin
          check("word_matches_pc", instruction, word_of(pc_out));
          if ((prev_nop || pc_out != prev_pc) && lit_i < lit_n) begin
            if (show_del) $display("deliver pc=%08h instr=%08h expect pc=%08h", pc_out, instruction, lit_arr[lit_i]);
            check("delivered_pc", pc_out, lit_arr[lit_i]);
            lit_i++;
          end
        end
        prev_nop = (instruction == NOP);
        prev_pc  = pc_out;
      end
      if (final_chk && !fin_done) begin
        check("pinned_deliveries_seen", 32'(lit_i), 32'(lit_n));
        fin_done = 1;
      end
      cap_hs   = imem_req && imem_gnt;
      cap_addr = imem_addr;
    end
  end

  // One clock: advance memory model past the edge, then drive next-cycle responses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
    if (cap_hs) pend.push_back(cap_addr);
    if (!rst_n) pend.delete();
    if (pend.size() > 0 && ($urandom_range(99) < rv_pct)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
  endtask

  task automatic add_lit(input logic [31:0] a);
    lit_arr[lit_n] = a;
    lit_n++;
  endtask

  task automatic wait_lits(input int bound);
    for (int k = 0; k < bound && lit_i < lit_n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0; flush_flag = 1'b0; wait_exe = 1'b0; jmp_addr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) tick();

    // Streaming from reset, then a 3-cycle stall mid-stream
    for (int i = 0; i < 16; i++) add_lit(RESET_PC + 32'(4 * i));
    rst_n = 1'b1;
    repeat (8) tick();
    wait_exe = 1'b1;
    repeat (3) tick();
    wait_exe = 1'b0;
    wait_lits(60);

    // Redirect to 0x100 with requests in flight
    rv_pct = 0;
    repeat (2) tick();
    flush_flag = 1'b1; jmp_addr = 32'h0000_0100; rv_pct = 100;
    tick();
    flush_flag = 1'b0;
    add_lit(32'h100); add_lit(32'h104); add_lit(32'h108);
    wait_lits(40);

    // Redirect coinciding with a response while one more is in flight
    gnt_pct = 0;
    for (int k = 0; k < 20 && pend.size() > 0; k++) tick();
    gnt_pct = 100; rv_pct = 0;
    repeat (3) tick();
    flush_flag = 1'b1; jmp_addr = 32'h0000_0200; imem_gnt = 1'b0;
    if (pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend[0]);
    end
    rv_pct = 100;
    tick();
    flush_flag = 1'b0;
    add_lit(32'h200); add_lit(32'h204); add_lit(32'h208);
    wait_lits(40);

    // Grant withheld for 5 cycles
    gnt_pct = 0;
    repeat (5) tick();
    gnt_pct = 100;
    repeat (6) tick();

    // Unaligned target and address wrap
    flush_flag = 1'b1; jmp_addr = 32'h0000_0103;
    tick();
    flush_flag = 1'b0;
    add_lit(32'h100); add_lit(32'h104);
    wait_lits(40);
    flush_flag = 1'b1; jmp_addr = 32'hFFFF_FFF8;
    tick();
    flush_flag = 1'b0;
    add_lit(32'hFFFF_FFF8); add_lit(32'hFFFF_FFFC); add_lit(32'h0); add_lit(32'h4);
    wait_lits(40);

    // Reset mid-transfer, then a stray response with nothing outstanding
    rv_pct = 50;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    gnt_pct = 0;
    tick();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    add_lit(RESET_PC); add_lit(RESET_PC + 32'd4); add_lit(RESET_PC + 32'd8);
    tick();
    gnt_pct = 100; rv_pct = 100;
    repeat (2) tick();
    wait_lits(40);

    // Randomized traffic, stalls and redirects
    show_del = 0;
    for (int blk = 0; blk < 60; blk++) begin
      gnt_pct = $urandom_range(100, 20);
      rv_pct  = $urandom_range(100, 20);
      for (int c = 0; c < 50; c++) begin
        tick();
        flush_flag = ($urandom_range(99) < 4);
        jmp_addr   = $urandom;
        wait_exe   = ($urandom_range(99) < 20);
      end
    end

    flush_flag = 1'b0; wait_exe = 1'b0; gnt_pct = 100; rv_pct = 100;
    repeat (10) tick();
    final_chk = 1;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
